// File: rtl/uart_rx_param_if.sv
// Held-word read port of the UART receiver: the receiver presents a word plus status flags, and the consumer strobes i_rd.
interface uart_rx_param_if #(
  parameter int DBIT_MAX = 9
);
  logic [DBIT_MAX-1:0] o_data;
  logic                o_valid;
  logic                o_par_err;
  logic                o_frm_err;
  logic                o_break;
  logic                o_ovr_err;
  logic                i_rd;

  modport master (
    output o_data, o_valid, o_par_err, o_frm_err, o_break, o_ovr_err,
    input  i_rd
  );

  modport slave (
    input  o_data, o_valid, o_par_err, o_frm_err, o_break, o_ovr_err,
    output i_rd
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with run-time framing, break/overrun reporting and a held output word.
// Optional build macro UART_RX_MAJORITY_EN: 3-tick majority vote at every sample point (needs OVS >= 8).
module uart_rx_param #(
  parameter int OVS      = 16,
  parameter int DBIT_MAX = 9
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx,
  input  logic                   i_baud_tick,
  input  logic [3:0]             i_data_num,
  input  logic [1:0]             i_stop_num,
  input  logic [2:0]             i_par,
  output logic                   o_busy,
  uart_rx_param_if.master        bus
);
  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  function automatic logic [3:0] clamp_dbits(input logic [3:0] req);
    if (req < 4'd5)                 return 4'd5;
    else if (req > 4'(DBIT_MAX))    return 4'(DBIT_MAX);
    else                            return req;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                rx_p0, rx_p1, rxs, samp;
  logic [2:0]          state, state_n;
  logic [SW-1:0]       s, s_n;
  logic [3:0]          n, n_n, dnum;
  logic [DBIT_MAX-1:0] sh, sh_n;
  logic                acc, acc_n, perr, perr_n, pbit, pbit_n;
  logic                ferr, ferr_n, brk, brk_n, stop2, stop2_n;
  logic                par_en, exp_par, done;

  // Stage p0/p1: two-flop synchroniser on the asynchronous line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rxs = rx_p1;

`ifdef UART_RX_MAJORITY_EN
  logic hist1, hist2;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else if (i_baud_tick) begin
      hist1 <= rxs;
      hist2 <= hist1;
    end
  end
  assign samp = maj3(hist2, hist1, rxs);
`else
  assign samp = rxs;
`endif

  assign dnum   = clamp_dbits(i_data_num);
  assign par_en = (i_par >= 3'd1) && (i_par <= 3'd4);

  always_comb begin
    state_n = state;  s_n = s;  n_n = n;  sh_n = sh;  acc_n = acc;
    perr_n = perr;  pbit_n = pbit;  ferr_n = ferr;  brk_n = brk;  stop2_n = stop2;
    done = 1'b0;
    case (i_par)
      3'b001:  exp_par = acc;
      3'b010:  exp_par = ~acc;
      3'b011:  exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        s_n     = '0;
      end
      START: if (i_baud_tick) begin
        if (s == S_HALF) begin
          if (samp) state_n = IDLE;
          else begin
            state_n = DATA;  s_n = '0;  n_n = '0;  sh_n = '0;  acc_n = 1'b0;
            perr_n = 1'b0;  pbit_n = 1'b0;  ferr_n = 1'b0;  brk_n = 1'b0;  stop2_n = 1'b0;
          end
        end else s_n = s + 1'b1;
      end
      DATA: if (i_baud_tick) begin
        if (s == S_LAST) begin
          sh_n[n] = samp;
          acc_n   = acc ^ samp;
          s_n     = '0;
          n_n     = n + 4'd1;
          // >= rather than == keeps the frame terminating if i_data_num shrinks mid-frame
          if (n >= dnum - 4'd1) state_n = par_en ? PARITY : STOP;
        end else s_n = s + 1'b1;
      end
      PARITY: if (i_baud_tick) begin
        if (s == S_LAST) begin
          pbit_n  = samp;
          perr_n  = (samp != exp_par);
          s_n     = '0;
          state_n = STOP;
        end else s_n = s + 1'b1;
      end
      STOP: if (i_baud_tick) begin
        if (!stop2 && s == S_LAST) begin
          s_n    = '0;
          ferr_n = ~samp;
          brk_n  = ~samp & ~(|sh) & ~pbit;
          if (i_stop_num == 2'b00) begin
            done    = 1'b1;
            state_n = brk_n ? WAIT_HIGH : IDLE;
          end else stop2_n = 1'b1;
        end else if (stop2 && (s == S_LAST || (i_stop_num == 2'b01 && s == S_HALF))) begin
          ferr_n  = ferr | ~samp;
          done    = 1'b1;
          state_n = brk ? WAIT_HIGH : IDLE;
        end else s_n = s + 1'b1;
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;  s <= '0;  n <= '0;  sh <= '0;  acc <= 1'b0;  perr <= 1'b0;
      pbit <= 1'b0;  ferr <= 1'b0;  brk <= 1'b0;  stop2 <= 1'b0;  o_busy <= 1'b0;
    end else begin
      state <= state_n;  s <= s_n;  n <= n_n;  sh <= sh_n;  acc <= acc_n;  perr <= perr_n;
      pbit <= pbit_n;  ferr <= ferr_n;  brk <= brk_n;  stop2 <= stop2_n;
      o_busy <= (state_n != IDLE);
    end
  end

  // Output stage: held word, consumed by i_rd; a completion while still held is an overrun
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_data    <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_par_err <= 1'b0;
      bus.o_frm_err <= 1'b0;
      bus.o_break   <= 1'b0;
      bus.o_ovr_err <= 1'b0;
    end else if (done && (!bus.o_valid || bus.i_rd)) begin
      bus.o_data    <= sh;
      bus.o_valid   <= 1'b1;
      bus.o_par_err <= perr;
      bus.o_frm_err <= ferr_n;
      bus.o_break   <= brk_n;
      if (bus.i_rd) bus.o_ovr_err <= 1'b0;
    end else if (done) begin
      bus.o_ovr_err <= 1'b1;
    end else if (bus.i_rd && bus.o_valid) begin
      bus.o_valid   <= 1'b0;
      bus.o_ovr_err <= 1'b0;
    end
  end
endmodule
